// File: rtl/mul_div_unit_pkg.sv
// Shared MDU operation codes, FSM states and the 64-bit HI/LO
// arithmetic helper used by the multiply/divide unit.
package mul_div_unit_pkg;

    localparam int MDU_OP_SIZE = 4;

    localparam logic [MDU_OP_SIZE-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_SIZE-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_SIZE-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MFHI  = 4'd7;
    localparam logic [MDU_OP_SIZE-1:0] MDU_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    // Returns {HI, LO}. Signed divide works on magnitudes so the
    // 0x80000000 / -1 case wraps to LO=0x80000000, HI=0 naturally.
    // A zero divisor is replaced by 1; callers discard that result.
    function automatic logic [63:0] mdu_calc(
        input logic [MDU_OP_SIZE-1:0] op,
        input logic [31:0]            a,
        input logic [31:0]            b
    );
        logic [63:0] r;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] m;
        r  = '0;
        ua = a;
        ub = (b == 32'd0) ? 32'd1 : b;
        q  = '0;
        m  = '0;
        case (op)
            MDU_MULT: begin
                r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            end
            MDU_MULTU: begin
                r = {32'd0, a} * {32'd0, b};
            end
            MDU_DIV: begin
                ua = a[31] ? 32'd0 - a : a;
                ub = b[31] ? 32'd0 - b : b;
                if (ub == 32'd0) ub = 32'd1;
                q = ua / ub;
                m = ua % ub;
                if (a[31] ^ b[31]) q = 32'd0 - q;
                if (a[31]) m = 32'd0 - m;
                r = {m, q};
            end
            MDU_DIVU: begin
                r = {ua % ub, ua / ub};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Define MDU_INSTANT_EN for a zero-latency (fast-simulation) build.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MDU_OP_SIZE-1:0] op,
    input  logic [31:0]            src_a,
    input  logic [31:0]            src_b,
    output logic                   busy,
    output logic [31:0]            result,
    output logic [31:0]            hi,
    output logic [31:0]            lo
);

    logic        is_mul;
    logic        is_div;
    logic        is_calc;
    logic        div_zero;
    logic [63:0] calc;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    assign is_mul   = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div   = (op == MDU_DIV) || (op == MDU_DIVU);
    assign is_calc  = is_mul || is_div;
    assign div_zero = is_div && (src_b == 32'd0);
    assign calc     = mdu_calc(op, src_a, src_b);

`ifdef MDU_INSTANT_EN

    // Arithmetic and moves commit to HI/LO at the start edge.
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (start) begin
            if (is_calc) begin
                if (!div_zero) begin
                    {hi_n, lo_n} = calc;
                end
            end else if (op == MDU_MTHI) begin
                hi_n = src_a;
            end else if (op == MDU_MTLO) begin
                lo_n = src_a;
            end
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

    assign busy = 1'b0;

`else

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state;
    mdu_state_e  state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [31:0] hi_tmp;
    logic [31:0] lo_tmp;
    logic [31:0] hi_tmp_n;
    logic [31:0] lo_tmp_n;
    logic        tmp_ok;
    logic        tmp_ok_n;

    // Next state: latch result on start, count down, commit at cnt==1.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi;
        lo_n     = lo;
        hi_tmp_n = hi_tmp;
        lo_tmp_n = lo_tmp;
        tmp_ok_n = tmp_ok;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (is_calc) begin
                        {hi_tmp_n, lo_tmp_n} = calc;
                        tmp_ok_n = !div_zero;
                        cnt_n    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_n  = BUSY;
                    end else if (op == MDU_MTHI) begin
                        hi_n = src_a;
                    end else if (op == MDU_MTLO) begin
                        lo_n = src_a;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    if (tmp_ok) begin
                        hi_n = hi_tmp;
                        lo_n = lo_tmp;
                    end
                end
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            tmp_ok <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi_tmp <= hi_tmp_n;
            lo_tmp <= lo_tmp_n;
            tmp_ok <= tmp_ok_n;
            hi     <= hi_n;
            lo     <= lo_n;
        end
    end

    assign busy = (state == BUSY);

`endif

    // Zero-latency mfhi/mflo read path.
    always_comb begin
        result = '0;
        if (op == MDU_MFHI) begin
            result = hi;
        end else if (op == MDU_MFLO) begin
            result = lo;
        end
    end

endmodule
